// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a fixed-latency single-port data memory between the CPU (port 0) and loader (port 1).
// Ack arrives LATENCY+2 cycles after the granting IDLE cycle; DMEM_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o,
  output logic              busy_o,
  output logic              grant_o
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_q;
  logic               grant_q;
  logic               gnt_d;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [DATA_W-1:0]  m0_rdata_q;
  logic [DATA_W-1:0]  m1_rdata_q;
  logic               m0_ack_q;
  logic               m1_ack_q;
  logic               busy_q;

  always_comb begin
    gnt_d = 1'b0;
    if (m0_req_i && m1_req_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt_d = 1'b0;
`else
      gnt_d = ~last_q;
`endif
    end else if (m1_req_i) begin
      gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            grant_q     <= gnt_d;
            last_q      <= gnt_d;
            mem_we_q    <= gnt_d ? m1_we_i    : m0_we_i;
            mem_addr_q  <= gnt_d ? m1_addr_i  : m0_addr_i;
            mem_wdata_q <= gnt_d ? m1_wdata_i : m0_wdata_i;
            mem_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          cnt_q    <= CNT_W'(LATENCY);
          state_q  <= WAIT;
        end
        WAIT: begin
          // Count of 1 marks the cycle the memory presents read data.
          if (cnt_q == CNT_W'(1)) begin
            if (!mem_we_q) begin
              if (grant_q) m1_rdata_q <= mem_rdata_i;
              else         m0_rdata_q <= mem_rdata_i;
            end
            if (grant_q) m1_ack_q <= 1'b1;
            else         m0_ack_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign m0_ack_o    = m0_ack_q;
  assign m1_ack_o    = m1_ack_q;
  assign busy_o      = busy_q;
  assign grant_o     = grant_q;
  assign cpu_stall_o = m0_req_i & ~m0_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level scheduling model checked every cycle, plus literal directed scenarios.
// A second instance built with LATENCY=1 covers the shortest-latency timing.
module tb_dmem_arbiter;

  localparam int L = 2;
  localparam logic [31:0] INIT_K = 32'h5A5A_A5A5;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o;
  logic        m0_ack_o, m1_ack_o, mem_en_o, mem_we_o, cpu_stall_o, busy_o, grant_o;

  logic [31:0] d1_rdata_i = '0;
  logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_addr, d1_wdata;
  logic        d1_m0_ack, d1_m1_ack, d1_en, d1_we, d1_stall, d1_busy, d1_grant;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .cpu_stall_o(cpu_stall_o), .busy_o(busy_o), .grant_o(grant_o)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(d1_m0_rdata), .m0_ack_o(d1_m0_ack),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(d1_m1_rdata), .m1_ack_o(d1_m1_ack),
    .mem_en_o(d1_en), .mem_we_o(d1_we), .mem_addr_o(d1_addr), .mem_wdata_o(d1_wdata),
    .mem_rdata_i(d1_rdata_i), .cpu_stall_o(d1_stall), .busy_o(d1_busy), .grant_o(d1_grant)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment memory: answers a read exactly L cycles after the strobe, noise otherwise.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  logic [31:0] ret_val = '0;
  int ecyc = 0, ret_cyc = -1, d1_ret = -1;

  initial forever begin
    @(posedge clk_i); #1;
    ecyc++;
    if (!rst_i) ret_cyc = -1;
    else if (mem_en_o) begin
      if (mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
      else begin
        ret_cyc = ecyc + L;
        ret_val = env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o] : (mem_addr_o ^ INIT_K);
      end
    end
    mem_rdata_i = (ecyc == ret_cyc) ? ret_val : $urandom;
    d1_rdata_i  = (ecyc == d1_ret) ? 32'hCAFE_F00D : $urandom;
  end

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : (a ^ INIT_K);
  endfunction

  // Reference model: one transaction at a time, scheduled from its grant cycle t0.
  bit          act = 1'b0, gp = 1'b0, gwe = 1'b0, lptr = 1'b1, egr = 1'b0;
  logic [31:0] ga = '0, gwd = '0, er0 = '0, er1 = '0;
  int          t0 = 0, n = 0;

  initial forever begin
    bit e_en, e_busy, e_done;
    @(negedge clk_i);
    n++;
    if (!rst_i) begin
      act = 1'b0; lptr = 1'b1; egr = 1'b0; er0 = '0; er1 = '0;
      chk1("rst_mem_en", mem_en_o, 1'b0);
      chk1("rst_mem_we", mem_we_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_ack0", m0_ack_o, 1'b0);
      chk1("rst_ack1", m1_ack_o, 1'b0);
      chk1("rst_grant", grant_o, 1'b0);
      chk32("rst_addr", mem_addr_o, 32'h0);
      chk32("rst_wdata", mem_wdata_o, 32'h0);
      chk32("rst_rdata0", m0_rdata_o, 32'h0);
      chk32("rst_rdata1", m1_rdata_o, 32'h0);
    end else begin
      e_en   = act && (n == t0 + 1);
      e_busy = act && (n > t0) && (n <= t0 + 2 + L);
      e_done = act && (n == t0 + 2 + L);
      if (e_done && !gwe) begin
        if (gp) er1 = mdl_rd(ga);
        else    er0 = mdl_rd(ga);
      end
      chk1("mem_en", mem_en_o, e_en);
      chk1("busy", busy_o, e_busy);
      chk1("ack0", m0_ack_o, e_done && !gp);
      chk1("ack1", m1_ack_o, e_done && gp);
      chk1("grant", grant_o, egr);
      chk32("rdata0", m0_rdata_o, er0);
      chk32("rdata1", m1_rdata_o, er1);
      chk1("cpu_stall", cpu_stall_o, m0_req_i & ~(e_done & ~gp));
      if (e_en) begin
        chk1("mem_we", mem_we_o, gwe);
        chk32("mem_addr", mem_addr_o, ga);
        chk32("mem_wdata", mem_wdata_o, gwd);
      end
      if (e_done) act = 1'b0;
      else if (!act && (m0_req_i || m1_req_i)) begin
        if (m0_req_i && m1_req_i) gp = FIXED ? 1'b0 : ~lptr;
        else                      gp = m1_req_i;
        gwe = gp ? m1_we_i : m0_we_i;
        ga  = gp ? m1_addr_i : m0_addr_i;
        gwd = gp ? m1_wdata_i : m0_wdata_i;
        if (gwe) mdl_mem[ga] = gwd;
        act = 1'b1; t0 = n; lptr = gp; egr = gp;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk_i); #2;
  endtask

  initial begin
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    chk1("reset_busy", busy_o, 1'b0);
    chk1("reset_grant", grant_o, 1'b0);
    chk32("reset_m0_rdata", m0_rdata_o, 32'h0);
    env_mem[32'h10] = 32'hDEAD_BEEF;
    mdl_mem[32'h10] = 32'hDEAD_BEEF;

    // Single read by port 0 out of reset; the LATENCY=1 instance sees the same request.
    next_cyc();
    rst_i = 1'b1; m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h10; d1_ret = ecyc + 2;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_cyc();
      if (k == 5) m0_req_i = 1'b0;
      #1;
      chk1($sformatf("rd_en_c%0d", k), mem_en_o, k == 1);
      chk1($sformatf("rd_ack0_c%0d", k), m0_ack_o, k == 4);
      chk1($sformatf("rd_stall_c%0d", k), cpu_stall_o, k <= 3);
      if (k == 1) begin
        chk32("rd_addr", mem_addr_o, 32'h10);
        chk1("rd_we", mem_we_o, 1'b0);
      end
      if (k == 4) chk32("rd_data", m0_rdata_o, 32'hDEAD_BEEF);
      if (k == 2 || k == 3) chk1($sformatf("l1_ack_c%0d", k), d1_m0_ack, k == 3);
      if (k == 3) chk32("l1_data", d1_m0_rdata, 32'hCAFE_F00D);
    end

    // Write by port 1.
    next_cyc();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h20; m1_wdata_i = 32'h55;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_cyc();
      if (k == 5) m1_req_i = 1'b0;
      #1;
      chk1($sformatf("wr_en_c%0d", k), mem_en_o, k == 1);
      chk1($sformatf("wr_ack1_c%0d", k), m1_ack_o, k == 4);
      chk32($sformatf("wr_rdata1_c%0d", k), m1_rdata_o, 32'h0);
      if (k == 1) begin
        chk1("wr_we", mem_we_o, 1'b1);
        chk32("wr_wdata", mem_wdata_o, 32'h55);
        chk32("wr_addr", mem_addr_o, 32'h20);
        chk1("wr_grant", grant_o, 1'b1);
      end
    end

    // Back-to-back reads by port 0, new address presented in the ack cycle.
    next_cyc();
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h30;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) next_cyc();
      if (k == 4) m0_addr_i = 32'h24;
      if (k == 10) m0_req_i = 1'b0;
      #1;
      chk1($sformatf("b2b_en_c%0d", k), mem_en_o, k == 1 || k == 6);
      chk1($sformatf("b2b_ack_c%0d", k), m0_ack_o, k == 4 || k == 9);
      if (k == 6) chk32("b2b_addr2", mem_addr_o, 32'h24);
    end

    // Contention from reset: both ports hold requests continuously.
    next_cyc();
    rst_i = 1'b0;
    next_cyc();
    rst_i = 1'b1;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h40;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h44;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) next_cyc();
      if (k == 20) begin m0_req_i = 1'b0; m1_req_i = 1'b0; end
      #1;
      chk1($sformatf("arb_ack0_c%0d", k), m0_ack_o,
           FIXED ? (k % 5 == 4) : (k == 4 || k == 14));
      chk1($sformatf("arb_ack1_c%0d", k), m1_ack_o,
           FIXED ? 1'b0 : (k == 9 || k == 19));
    end

    // Reset asserted while the read waits on memory.
    next_cyc();
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h10;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) next_cyc();
      if (k == 2) begin rst_i = 1'b0; m0_req_i = 1'b0; end
      if (k == 4) rst_i = 1'b1;
      #1;
      if (k == 2) begin
        chk1("mid_busy", busy_o, 1'b0);
        chk1("mid_en", mem_en_o, 1'b0);
        chk32("mid_addr", mem_addr_o, 32'h0);
        chk32("mid_rdata0", m0_rdata_o, 32'h0);
        chk1("mid_stall", cpu_stall_o, 1'b0);
      end
      if (k >= 2) chk1($sformatf("mid_noack_c%0d", k), m0_ack_o, 1'b0);
    end
    next_cyc();
    m0_req_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) next_cyc();
      if (k == 5) m0_req_i = 1'b0;
      #1;
      chk1($sformatf("post_ack_c%0d", k), m0_ack_o, k == 4);
      if (k == 4) chk32("post_data", m0_rdata_o, 32'hDEAD_BEEF);
    end

    // Randomised traffic with occasional one-cycle resets.
    for (int c = 0; c < 4000; c++) begin
      next_cyc();
      if (!rst_i) rst_i = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_i = 1'b0;
      if (!m0_req_i || m0_ack_o) begin
        m0_req_i   = ($urandom_range(0, 3) != 0);
        m0_we_i    = 1'($urandom_range(0, 1));
        m0_addr_i  = 32'($urandom_range(0, 15)) << 2;
        m0_wdata_i = $urandom;
      end
      if (!m1_req_i || m1_ack_o) begin
        m1_req_i   = ($urandom_range(0, 2) == 0);
        m1_we_i    = 1'($urandom_range(0, 1));
        m1_addr_i  = 32'($urandom_range(0, 15)) << 2;
        m1_wdata_i = $urandom;
      end
    end

    m0_req_i = 1'b0; m1_req_i = 1'b0; rst_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #7;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: the CPU MEM stage, driven from the EX/MEM pipeline register.
  - port 1: the external loader/debug port.
- Sequences each access against a fixed-latency memory.
- Grants between the ports round-robin.
- Raises a stall to the pipeline while the CPU access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, memory read latency in cycles; legal range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- m0_req_i  in  1  CPU request; held until m0_ack_o.
- m0_we_i  in  1  CPU write enable (1 = store).
- m0_addr_i  in  ADDR_W  CPU address.
- m0_wdata_i  in  DATA_W  CPU store data.
- m0_rdata_o  out  DATA_W  CPU load data; valid while m0_ack_o is high.
- m0_ack_o  out  1  CPU completion pulse.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o: same as port 0, for the loader port.
- mem_en_o  out  1  memory access strobe, one cycle.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data.
- cpu_stall_o  out  1  equals m0_req_i & ~m0_ack_o (combinational).
- busy_o  out  1  high in any state other than IDLE.
- grant_o  out  1  index of the current or most recent grant.

Behaviour:
- Reset (rst_i low, asynchronous, including mid-transaction):
  - state = IDLE.
  - mem_en_o, mem_we_o, m0_ack_o, m1_ack_o, busy_o = 0.
  - mem_addr_o, mem_wdata_o, m0_rdata_o, m1_rdata_o = 0.
  - grant_o = 0; last-grant pointer = 1, so port 0 wins the first tie.
  - The in-flight access is abandoned; no ack is issued for it.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs except cpu_stall_o are registered.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one req high: grant that port.
  - Both high: grant the port not equal to the last-grant pointer.
  - On grant: latch we/addr/wdata, set grant_o and the pointer, go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en_o = 1; mem_we_o/addr/wdata hold the latched values.
  - Load counter with LATENCY; go to WAIT.
- WAIT:
  - mem_en_o = 0; counter decrements each cycle.
  - Read data is valid on mem_rdata_i LATENCY cycles after the ISSUE cycle. The arbiter captures it into the granted port's rdata register in that cycle, then goes to DONE.
  - Writes use the same timing; rdata registers are not updated on writes.
- DONE (1 cycle):
  - ack of the granted port = 1; the other ack = 0.
  - Next state is IDLE.
  - A requester that still holds req in the following IDLE cycle is treated as issuing a new transaction.
- Latency: req seen in IDLE cycle 0 -> mem_en_o in cycle 1 -> data captured in cycle 1+LATENCY -> ack in cycle 2+LATENCY.
- Throughput: one access per LATENCY+3 cycles.
- rdata hold: rdata_o keeps its value after ack until that port's next read completes.
- Counter width: $clog2(LATENCY+1); it never wraps because it is reloaded in ISSUE.
- Requester contract: the arbiter ignores req changes outside IDLE. Dropping req before ack is a protocol error; the arbiter still completes the access and still pulses ack.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 (CPU) always wins ties; the last-grant pointer is still updated but is not used for the decision.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read: LATENCY=2, port 0 reads addr 0x10, memory returns 0xDEADBEEF.
  - mem_en_o high in cycle 1 with mem_addr_o=0x10, mem_we_o=0.
  - m0_ack_o high in cycle 4 only, with m0_rdata_o=0xDEADBEEF.
  - cpu_stall_o high in cycles 0-3.
- Write: port 1 writes 0x00000055 to addr 0x20.
  - mem_en_o=1, mem_we_o=1, mem_wdata_o=0x55 in cycle 1.
  - m1_ack_o in cycle 4; m1_rdata_o unchanged.
- Contention: both ports request continuously from reset.
  - Grants alternate 0,1,0,1.
  - Each ack is 5 cycles apart at LATENCY=2.
  - With DMEM_ARB_FIXED_PRIO_EN defined, port 0 is granted every time.
- Back-to-back: port 0 holds req across its ack with a new addr 0x24.
  - Second mem_en_o occurs 5 cycles after the first, with addr 0x24.
- Reset mid-access: assert rst_i low in the WAIT cycle.
  - All outputs go to 0 immediately; no ack is issued.
  - After release, a fresh port 0 read completes normally.
- LATENCY=1 build: a read issued in cycle 0 gets its ack in cycle 3, and data is captured in cycle 2.
